// File: rtl/custom_ip_bridge_pkg.sv
// Shared definitions for the APB-to-IP register bridge: FSM states,
// channel count, register offsets and STATUS field positions.
package custom_ip_bridge_pkg;

    localparam int unsigned NUM_CH    = 3;
    localparam int unsigned ADDR_W    = 12;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned CH_STRIDE = 4;

    localparam logic [ADDR_W-1:0] WR_CH_BASE = 12'h000;
    localparam logic [ADDR_W-1:0] RD_CH_BASE = 12'h010;
    localparam logic [ADDR_W-1:0] STATUS_OFF = 12'h020;

    localparam int unsigned STATUS_VALID_LSB   = 0;
    localparam int unsigned STATUS_VALID_W     = 3;
    localparam int unsigned STATUS_TIMEOUT_BIT = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_ACK,
        ST_RESP
    } state_e;

    // Byte address of channel ch within a per-channel register bank
    function automatic logic [ADDR_W-1:0] ch_addr(input logic [ADDR_W-1:0] base,
                                                  input int unsigned       ch);
        return base + ADDR_W'(ch * CH_STRIDE);
    endfunction

endpackage

// File: rtl/custom_ip_bridge_capture.sv
// One read-back channel: shadow data bit plus sticky valid flag.
// A capture in the same cycle as a read-clear wins.
module custom_ip_bridge_capture
    import custom_ip_bridge_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic cap_en_i,
    input  logic cap_data_i,
    input  logic clr_i,
    output logic shadow_o,
    output logic valid_o
);

    logic shadow_q, shadow_d;
    logic valid_q, valid_d;

    // Capture has priority over the read-clear
    always_comb begin
        shadow_d = shadow_q;
        valid_d  = valid_q;
        if (cap_en_i) begin
            shadow_d = cap_data_i;
            valid_d  = 1'b1;
        end else if (clr_i) begin
            valid_d = 1'b0;
        end
    end

    // Shadow/valid state
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            shadow_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            valid_q  <= valid_d;
        end
    end

    assign shadow_o = shadow_q;
    assign valid_o  = valid_q;

endmodule

// File: rtl/custom_ip_reg_bridge.sv
// APB slave bridging per-channel single-bit writes (with acknowledge)
// and captured read-back bits of a downstream IP.
// Optional macro CUSTOM_IP_BRIDGE_TIMEOUT_EN adds a write-ack timeout.
module custom_ip_reg_bridge #(
    parameter int unsigned NUM_CH         = custom_ip_bridge_pkg::NUM_CH,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [custom_ip_bridge_pkg::ADDR_W-1:0] paddr_i,
    input  logic                                    psel_i,
    input  logic                                    penable_i,
    input  logic                                    pwrite_i,
    input  logic [custom_ip_bridge_pkg::DATA_W-1:0] pwdata_i,
    output logic [custom_ip_bridge_pkg::DATA_W-1:0] prdata_o,
    output logic                                    pready_o,
    output logic                                    pslverr_o,
    output logic [NUM_CH-1:0]                       reg2ip_data_o,
    output logic [NUM_CH-1:0]                       reg2ip_en_o,
    input  logic [NUM_CH-1:0]                       reg2ip_ack_i,
    input  logic [NUM_CH-1:0]                       ip2reg_data_i,
    input  logic [NUM_CH-1:0]                       ip2reg_en_i
);

    import custom_ip_bridge_pkg::*;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   prdata_q, prdata_d;
    logic                pready_q, pready_d;
    logic                pslverr_q, pslverr_d;
    logic [NUM_CH-1:0]   data_q, data_d;
    logic [NUM_CH-1:0]   en_q, en_d;
    logic [NUM_CH-1:0]   clr_mask_q, clr_mask_d;
    logic                clr_sticky_q, clr_sticky_d;

    logic [NUM_CH-1:0]   shadow, valid, clr_c;
    logic [NUM_CH-1:0]   wr_hit_c, rd_hit_c;
    logic                status_hit_c, ack_c, timeout_c, sticky_c, unused_c;
    logic [DATA_W-1:0]   rd_data_c;

    // Address decode and read-data mux
    always_comb begin
        wr_hit_c     = '0;
        rd_hit_c     = '0;
        rd_data_c    = '0;
        status_hit_c = (paddr_i == STATUS_OFF);
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            wr_hit_c[i] = (paddr_i == ch_addr(WR_CH_BASE, i));
            rd_hit_c[i] = (paddr_i == ch_addr(RD_CH_BASE, i));
            if (rd_hit_c[i]) begin
                rd_data_c = DATA_W'({valid[i], shadow[i]});
            end
        end
        if (status_hit_c) begin
            rd_data_c[STATUS_TIMEOUT_BIT] = sticky_c;
            for (int unsigned i = 0; i < STATUS_VALID_W; i++) begin
                if (i < NUM_CH) begin
                    rd_data_c[STATUS_VALID_LSB + i] = valid[i];
                end
            end
        end
    end

    assign ack_c = |(reg2ip_ack_i & en_q);
    assign clr_c = (state_q == ST_RESP) ? clr_mask_q : '0;

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        prdata_d     = '0;
        pready_d     = 1'b0;
        pslverr_d    = 1'b0;
        data_d       = data_q;
        en_d         = en_q;
        clr_mask_d   = clr_mask_q;
        clr_sticky_d = clr_sticky_q;
        case (state_q)
            ST_IDLE: begin
                if (psel_i && penable_i) begin
                    if (pwrite_i && (|wr_hit_c)) begin
                        en_d    = wr_hit_c;
                        data_d  = (data_q & ~wr_hit_c) | (wr_hit_c & {NUM_CH{pwdata_i[0]}});
                        state_d = ST_WAIT_ACK;
                    end else if (!pwrite_i && (|rd_hit_c)) begin
                        prdata_d   = rd_data_c;
                        pready_d   = 1'b1;
                        clr_mask_d = rd_hit_c;
                        state_d    = ST_RESP;
                    end else if (!pwrite_i && status_hit_c) begin
                        prdata_d     = rd_data_c;
                        pready_d     = 1'b1;
                        clr_sticky_d = 1'b1;
                        state_d      = ST_RESP;
                    end else begin
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                        state_d   = ST_RESP;
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (ack_c) begin
                    en_d     = '0;
                    pready_d = 1'b1;
                    state_d  = ST_RESP;
                end else if (timeout_c) begin
                    en_d      = '0;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                clr_mask_d   = '0;
                clr_sticky_d = 1'b0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            prdata_q     <= '0;
            pready_q     <= 1'b0;
            pslverr_q    <= 1'b0;
            data_q       <= '0;
            en_q         <= '0;
            clr_mask_q   <= '0;
            clr_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prdata_q     <= prdata_d;
            pready_q     <= pready_d;
            pslverr_q    <= pslverr_d;
            data_q       <= data_d;
            en_q         <= en_d;
            clr_mask_q   <= clr_mask_d;
            clr_sticky_q <= clr_sticky_d;
        end
    end

`ifdef CUSTOM_IP_BRIDGE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sticky_q, sticky_d;

    assign timeout_c = (state_q == ST_WAIT_ACK) && !ack_c &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count unacknowledged WAIT_ACK cycles; sticky records any expiry until STATUS is read
    always_comb begin
        cnt_d    = '0;
        sticky_d = sticky_q;
        if (state_q == ST_WAIT_ACK && !ack_c && !timeout_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (timeout_c) begin
            sticky_d = 1'b1;
        end else if (state_q == ST_RESP && clr_sticky_q) begin
            sticky_d = 1'b0;
        end
    end

    // Timeout counter and sticky flag
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign sticky_c = sticky_q;
    assign unused_c = ^pwdata_i[DATA_W-1:1];
`else
    assign timeout_c = 1'b0;
    assign sticky_c  = 1'b0;
    assign unused_c  = ^{pwdata_i[DATA_W-1:1], (TIMEOUT_CYCLES != 0)};
`endif

    // Per-channel capture of IP read-back bits
    for (genvar g = 0; g < NUM_CH; g++) begin : g_cap
        custom_ip_bridge_capture u_cap (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .cap_en_i   (ip2reg_en_i[g]),
            .cap_data_i (ip2reg_data_i[g]),
            .clr_i      (clr_c[g]),
            .shadow_o   (shadow[g]),
            .valid_o    (valid[g])
        );
    end

    assign prdata_o      = prdata_q;
    assign pready_o      = pready_q;
    assign pslverr_o     = pslverr_q;
    assign reg2ip_data_o = data_q;
    assign reg2ip_en_o   = en_q;

endmodule

// File: tb/tb_custom_ip_reg_bridge.sv
// Self-checking bench for custom_ip_reg_bridge: expected APB responses are
// queued from a small register model and compared when pready_o appears.
module tb_custom_ip_reg_bridge;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [11:0] paddr_i;
    logic        psel_i, penable_i, pwrite_i;
    logic [31:0] pwdata_i;
    logic [31:0] prdata_o;
    logic        pready_o, pslverr_o;
    logic [2:0]  reg2ip_data_o, reg2ip_en_o, reg2ip_ack_i;
    logic [2:0]  ip2reg_data_i, ip2reg_en_i;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    logic [2:0] m_shadow = '0;
    logic [2:0] m_valid  = '0;
    logic [2:0] m_data   = '0;
    logic       m_sticky = 1'b0;

    always #5 clk_i = ~clk_i;

    custom_ip_reg_bridge dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .paddr_i       (paddr_i),
        .psel_i        (psel_i),
        .penable_i     (penable_i),
        .pwrite_i      (pwrite_i),
        .pwdata_i      (pwdata_i),
        .prdata_o      (prdata_o),
        .pready_o      (pready_o),
        .pslverr_o     (pslverr_o),
        .reg2ip_data_o (reg2ip_data_o),
        .reg2ip_en_o   (reg2ip_en_o),
        .reg2ip_ack_i  (reg2ip_ack_i),
        .ip2reg_data_i (ip2reg_data_i),
        .ip2reg_en_i   (ip2reg_en_i)
    );

    initial begin
        #500000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    // Drive capture strobes for one cycle and mirror them in the model
    task automatic capture(input logic [2:0] en, input logic [2:0] data);
        ip2reg_en_i   = en;
        ip2reg_data_i = data;
        @(posedge clk_i); #1;
        ip2reg_en_i = '0;
        m_valid  = m_valid | en;
        m_shadow = (m_shadow & ~en) | (data & en);
    endtask

    // One APB transfer; ack_dly = cycles of reg2ip_en before ack (0 = never).
    // cap_en/cap_data are driven during the RESP cycle to race a read-clear.
    task automatic apb_xfer(input logic [11:0] addr, input logic wr, input logic [31:0] wdata,
                            input int ack_dly, input logic [2:0] cap_en, input logic [2:0] cap_data,
                            input string name);
        resp_t      e, r;
        int         kind = 0;
        int         ch = 0;
        int         n_en = 0;
        int         exp_cyc = 0;
        logic [2:0] exp_en = '0;
        bit         done = 0;
        e.rdata = '0;
        e.err   = 1'b1;
        if (wr && addr < 12'h00C && addr[1:0] == 2'b00) begin
            kind = 1; ch = int'(addr[3:2]);
            m_data[ch] = wdata[0];
            exp_en = 3'(1 << ch);
            exp_cyc = (ack_dly == 0) ? 16 : ack_dly;
            e.err = (ack_dly == 0);
        end else if (!wr && addr >= 12'h010 && addr < 12'h01C && addr[1:0] == 2'b00) begin
            kind = 2; ch = int'(addr[3:2]);
            e.rdata = {30'b0, m_valid[ch], m_shadow[ch]};
            e.err = 1'b0;
        end else if (!wr && addr == 12'h020) begin
            kind = 3;
            e.rdata = {24'b0, m_sticky, 4'b0, m_valid};
            e.err = 1'b0;
        end
        exp_q.push_back(e);
        reg2ip_ack_i = '0;
        paddr_i = addr; pwrite_i = wr; pwdata_i = wdata;
        psel_i = 1'b1; penable_i = 1'b0;
        @(posedge clk_i); #1;
        penable_i = 1'b1;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            @(posedge clk_i); #1;
            if (reg2ip_en_o !== 3'b000) begin
                n_en++;
                checks++;
                if (reg2ip_en_o !== exp_en) begin
                    errors++;
                    $display("FAIL %s en_pattern got %b exp %b", name, reg2ip_en_o, exp_en);
                end
                if (ack_dly != 0 && n_en == ack_dly) reg2ip_ack_i = reg2ip_en_o;
            end else begin
                reg2ip_ack_i = '0;
            end
            checks++;
            if (reg2ip_data_o !== m_data) begin
                errors++;
                $display("FAIL %s reg2ip_data got %b exp %b", name, reg2ip_data_o, m_data);
            end
            if (pready_o === 1'b1) begin
                done = 1;
                r = exp_q.pop_front();
                checks++;
                if (prdata_o !== r.rdata) begin
                    errors++;
                    $display("FAIL %s prdata got %h exp %h", name, prdata_o, r.rdata);
                end
                checks++;
                if (pslverr_o !== r.err) begin
                    errors++;
                    $display("FAIL %s pslverr got %b exp %b", name, pslverr_o, r.err);
                end
                checks++;
                if (n_en != exp_cyc) begin
                    errors++;
                    $display("FAIL %s en_cycles got %0d exp %0d", name, n_en, exp_cyc);
                end
                psel_i = 1'b0; penable_i = 1'b0;
                ip2reg_en_i = cap_en; ip2reg_data_i = cap_data;
                if (kind == 1 && ack_dly == 0) m_sticky = 1'b1;
                if (kind == 2) m_valid[ch] = 1'b0;
                if (kind == 3) m_sticky = 1'b0;
                m_valid  = m_valid | cap_en;
                m_shadow = (m_shadow & ~cap_en) | (cap_data & cap_en);
            end else begin
                checks++;
                if (pslverr_o !== 1'b0) begin
                    errors++;
                    $display("FAIL %s pslverr_outside_resp got %b exp 0", name, pslverr_o);
                end
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s no_pready got 0 exp 1 within 64 cycles", name);
            void'(exp_q.pop_front());
            psel_i = 1'b0; penable_i = 1'b0;
        end
        reg2ip_ack_i = '0;
        @(posedge clk_i); #1;
        ip2reg_en_i = '0;
        checks++;
        if (pready_o !== 1'b0 || reg2ip_en_o !== 3'b000) begin
            errors++;
            $display("FAIL %s after_resp pready=%b en=%b exp 0/000", name, pready_o, reg2ip_en_o);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        paddr_i = '0; psel_i = 0; penable_i = 0; pwrite_i = 0; pwdata_i = '0;
        reg2ip_ack_i = '0; ip2reg_data_i = '0; ip2reg_en_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if (prdata_o !== 32'h0) begin errors++; $display("FAIL reset prdata got %h exp 0", prdata_o); end
        checks++; if (pready_o !== 1'b0) begin errors++; $display("FAIL reset pready got %b exp 0", pready_o); end
        checks++; if (pslverr_o !== 1'b0) begin errors++; $display("FAIL reset pslverr got %b exp 0", pslverr_o); end
        checks++; if (reg2ip_data_o !== 3'b0) begin errors++; $display("FAIL reset data got %b exp 0", reg2ip_data_o); end
        checks++; if (reg2ip_en_o !== 3'b0) begin errors++; $display("FAIL reset en got %b exp 0", reg2ip_en_o); end
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        apb_xfer(12'h020, 1'b0, 32'h0, 0, 3'b0, 3'b0, "reset_status");
        apb_xfer(12'h014, 1'b0, 32'h0, 0, 3'b0, 3'b0, "reset_rd_ch1");
    endtask

    task automatic test_write();
        apb_xfer(12'h004, 1'b1, 32'h1, 2, 3'b0, 3'b0, "wr_ch1_ack2");
        apb_xfer(12'h000, 1'b1, 32'hFFFF_FFFF, 1, 3'b0, 3'b0, "wr_ch0_ack1");
        apb_xfer(12'h008, 1'b1, 32'h1, 4, 3'b0, 3'b0, "wr_ch2_ack4");
        apb_xfer(12'h004, 1'b1, 32'hFFFF_FFFE, 3, 3'b0, 3'b0, "wr_ch1_zero");
    endtask

    task automatic test_capture_read();
        capture(3'b001, 3'b001);
        apb_xfer(12'h010, 1'b0, 32'h0, 0, 3'b0, 3'b0, "rd_ch0_first");
        apb_xfer(12'h010, 1'b0, 32'h0, 0, 3'b0, 3'b0, "rd_ch0_second");
        capture(3'b010, 3'b000);
        apb_xfer(12'h014, 1'b0, 32'h0, 0, 3'b0, 3'b0, "rd_ch1_zero");
    endtask

    task automatic test_clear_race();
        capture(3'b100, 3'b000);
        apb_xfer(12'h018, 1'b0, 32'h0, 0, 3'b100, 3'b100, "race_rd_ch2");
        apb_xfer(12'h018, 1'b0, 32'h0, 0, 3'b0, 3'b0, "race_rd_ch2_after");
        apb_xfer(12'h018, 1'b0, 32'h0, 0, 3'b0, 3'b0, "race_rd_ch2_cleared");
    endtask

    task automatic test_errors();
        apb_xfer(12'h000, 1'b0, 32'h0, 0, 3'b0, 3'b0, "err_rd_wr_reg");
        apb_xfer(12'h030, 1'b1, 32'h1, 1, 3'b0, 3'b0, "err_wr_unmapped");
        apb_xfer(12'h010, 1'b1, 32'h1, 1, 3'b0, 3'b0, "err_wr_rd_reg");
        apb_xfer(12'h020, 1'b1, 32'h1, 1, 3'b0, 3'b0, "err_wr_status");
        apb_xfer(12'h00C, 1'b1, 32'h1, 1, 3'b0, 3'b0, "err_wr_ch3");
        apb_xfer(12'h005, 1'b1, 32'h1, 1, 3'b0, 3'b0, "err_wr_misaligned");
        apb_xfer(12'h01C, 1'b0, 32'h0, 0, 3'b0, 3'b0, "err_rd_ch3");
    endtask

    task automatic test_status();
        capture(3'b011, 3'b010);
        apb_xfer(12'h020, 1'b0, 32'h0, 0, 3'b0, 3'b0, "status_valid");
        apb_xfer(12'h010, 1'b0, 32'h0, 0, 3'b0, 3'b0, "status_rd_ch0");
        apb_xfer(12'h014, 1'b0, 32'h0, 0, 3'b0, 3'b0, "status_rd_ch1");
        apb_xfer(12'h020, 1'b0, 32'h0, 0, 3'b0, 3'b0, "status_empty");
    endtask

`ifdef CUSTOM_IP_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        apb_xfer(12'h008, 1'b1, 32'h1, 0, 3'b0, 3'b0, "timeout_wr_ch2");
        apb_xfer(12'h020, 1'b0, 32'h0, 0, 3'b0, 3'b0, "timeout_status_set");
        apb_xfer(12'h020, 1'b0, 32'h0, 0, 3'b0, 3'b0, "timeout_status_clr");
    endtask
`endif

    task automatic test_back_to_back();
        for (int k = 0; k < 10; k++) begin
            logic [11:0] a;
            int          c;
            c = int'($urandom_range(0, 2));
            if (k % 3 == 0) capture(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 1) == 1) begin
                a = 12'(c * 4);
                apb_xfer(a, 1'b1, $urandom, int'($urandom_range(1, 4)), 3'b0, 3'b0, "b2b_wr");
            end else begin
                a = 12'h010 + 12'(c * 4);
                apb_xfer(a, 1'b0, 32'h0, 0, 3'b0, 3'b0, "b2b_rd");
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        bit seen = 0;
        reg2ip_ack_i = '0;
        paddr_i = 12'h000; pwrite_i = 1'b1; pwdata_i = 32'h1;
        psel_i = 1'b1; penable_i = 1'b0;
        @(posedge clk_i); #1;
        penable_i = 1'b1;
        for (int cyc = 0; cyc < 8 && !seen; cyc++) begin
            @(posedge clk_i); #1;
            if (reg2ip_en_o !== 3'b000) seen = 1;
        end
        checks++;
        if (reg2ip_en_o !== 3'b001) begin
            errors++;
            $display("FAIL rst_mid en_before got %b exp 001", reg2ip_en_o);
        end
        @(posedge clk_i); #1;
        rst_ni = 1'b0; psel_i = 1'b0; penable_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        m_shadow = '0; m_valid = '0; m_data = '0; m_sticky = 1'b0;
        checks++; if (reg2ip_en_o !== 3'b0) begin errors++; $display("FAIL rst_mid en got %b exp 000", reg2ip_en_o); end
        checks++; if (reg2ip_data_o !== 3'b0) begin errors++; $display("FAIL rst_mid data got %b exp 000", reg2ip_data_o); end
        checks++; if (pready_o !== 1'b0 || pslverr_o !== 1'b0) begin errors++; $display("FAIL rst_mid resp got %b%b exp 00", pready_o, pslverr_o); end
        checks++; if (prdata_o !== 32'h0) begin errors++; $display("FAIL rst_mid prdata got %h exp 0", prdata_o); end
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(posedge clk_i); #1;
            checks++;
            if (pready_o !== 1'b0 || reg2ip_en_o !== 3'b0) begin
                errors++;
                $display("FAIL rst_mid no_resp pready=%b en=%b exp 0/000", pready_o, reg2ip_en_o);
            end
        end
        apb_xfer(12'h020, 1'b0, 32'h0, 0, 3'b0, 3'b0, "rst_mid_status");
        apb_xfer(12'h004, 1'b1, 32'h1, 1, 3'b0, 3'b0, "rst_mid_wr_ch1");
    endtask

    initial begin
        test_reset();
        test_write();
        test_capture_read();
        test_clear_race();
        test_errors();
        test_status();
`ifdef CUSTOM_IP_BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        test_back_to_back();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
